// File: rtl/reg_arb_pkg.sv
// Shared constants for the round-robin register arbiter.
// Contents: FSM state encodings and the requester-ID width helper.
// Imported by reg_arbiter and reg_arb_rr_pick.
package reg_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Width of a requester ID. It is never allowed below 1 bit, so a
    // degenerate single-requester build still has a legal vector.
    function automatic int reg_arb_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after ptr, wrapping to 0.
// Latency: zero cycles (purely combinational).
// Backpressure: none; any=0 means no requester is asking.
// Ports: req (request vector), ptr (search start), any (some req set), winner (ID).
module reg_arb_rr_pick import reg_arb_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IDW  = reg_arb_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    int idx;

    // ptr always holds a value below NREQ, so one subtraction is enough
    // to wrap the index, even when NREQ is not a power of two.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit storage register between NREQ writers.
// Latency: req in cycle N -> registered gnt in N+1 -> data_out in N+2; one write every 2 cycles.
// Backpressure: a requester holds req and its data until it sees gnt; if req drops during gnt, the write is cancelled.
// Ports: req/req_data (per-requester write), clr (clear while idle), gnt (one-hot),
//        data_out/owner/valid (stored value, last writer, written-since-clear).
// Option: define REG_ARB_LOCK_EN to add the lock port and the LOCKED ownership-hold state.
module reg_arbiter import reg_arb_pkg::*; #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = reg_arb_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clr,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      data_out,
    output logic [IDW-1:0]        owner,
    output logic                  valid
);

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_q;      // requester granted this round
    logic             rr_any;
    logic [IDW-1:0]   rr_win;
    logic [WIDTH-1:0] win_dat;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    reg_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (rr_any),
        .winner (rr_win)
    );

    assign win_dat = req_data[win_q*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            data_out <= '0;
            owner    <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
            win_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt <= '0;
                    // A clear has priority over any request in the same cycle.
                    if (clr) begin
                        data_out <= '0;
                        valid    <= 1'b0;
                    end else if (rr_any) begin
                        gnt   <= NREQ'(1) << rr_win;
                        win_q <= rr_win;
                        state <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                    // The write commits only if the winner still asserts req
                    // while it can see gnt. Otherwise the round is dropped and
                    // the pointer stays, so the same requester is first again.
                    if (req[win_q]) begin
                        data_out <= win_dat;
                        owner    <= win_q;
                        valid    <= 1'b1;
`ifdef REG_ARB_LOCK_EN
                        if (lock[win_q]) begin
                            state <= ST_LOCKED;
                        end else begin
                            ptr <= next_id(win_q);
                        end
`else
                        ptr <= next_id(win_q);
`endif
                    end
                end

`ifdef REG_ARB_LOCK_EN
                ST_LOCKED: begin
                    gnt <= '0;
                    // If the lock is released in the same cycle as a request,
                    // the release wins. The owner then competes normally,
                    // starting just after itself.
                    if (!lock[owner]) begin
                        ptr   <= next_id(owner);
                        state <= ST_IDLE;
                    end else if (req[owner]) begin
                        gnt   <= NREQ'(1) << owner;
                        win_q <= owner;
                        state <= ST_GRANT;
                    end
                end
`endif

                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_arbiter.md
Name: reg_arbiter

Overview:
- Shares one WIDTH-bit storage register between NREQ requesters using round-robin arbitration with a registered grant handshake.
- Holds the stored value, the ID of the last writer, and a valid flag.
- Sits in front of the storage register and replaces direct load/data_in driving when more than one agent must write it.

Parameters:
WIDTH, 8, data width of the stored register
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), width of requester ID; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester write request, level
req_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
clr  in  1  synchronous clear of stored value
gnt  out  NREQ  one-hot grant, registered
data_out  out  WIDTH  stored register value
owner  out  IDW  ID of last requester that wrote data_out
valid  out  1  data_out written since last reset/clear
lock  in  NREQ  per-requester ownership hold; present only with REG_ARB_LOCK_EN

Behaviour:
- Reset (rst_n low, async): state=IDLE, gnt=0, data_out=0, owner=0, valid=0, rr pointer=0.
- States: IDLE, GRANT (LOCKED only with the macro).
- IDLE, clr=1: data_out<=0, valid<=0, owner unchanged, stay IDLE. clr beats any req.
- IDLE, clr=0, req!=0: winner = first set req bit at or after the pointer, wrapping NREQ-1 to 0. gnt<=onehot(winner), go to GRANT.
- IDLE, req==0: stay IDLE, gnt=0.
- GRANT, one cycle with gnt visible:
  - If req[winner] is still 1 at the clock edge: data_out<=req_data[winner], owner<=winner, valid<=1, pointer<=(winner+1) mod NREQ.
  - If req[winner] dropped: write is cancelled; data_out, owner and pointer are unchanged.
  - gnt<=0 and return to IDLE either way.
- Requester rule: hold req high and req_data stable until gnt is seen; deassert req the cycle after gnt unless another write is wanted.
- Latency: req high in cycle N (IDLE) -> gnt high in N+1 -> data_out updated in N+2. Peak throughput is one write per 2 cycles.
- clr during GRANT is ignored (not queued). It must be held until IDLE to take effect.
- Fairness: a continuously requesting agent waits at most NREQ-1 writes by others.
- Mid-operation reset: async return to reset values; an in-flight GRANT write is lost.

Optional Feature:
- Macro REG_ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - If lock[winner]=1 on the GRANT edge where the write occurs, go to LOCKED instead of IDLE; the pointer is not advanced.
  - LOCKED: only the locked owner is considered. req[owner]=1 -> gnt<=onehot(owner), go to GRANT. lock[owner]=0 -> pointer<=owner+1, go to IDLE.
  - clr is ignored in LOCKED.
  - Reset exits LOCKED.
- Undefined: no lock port, no LOCKED state, behaviour exactly as above.

Decomposition:
- Package reg_arb_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, LOCKED=2'd2) and the IDW width function.
- Sub-module reg_arb_rr_pick: combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: any, winner ID.
  - Reused by LOCKED-free and LOCKED builds.

Test Plan (WIDTH=8, NREQ=4):
- Reset then single req[2] with data 8'h55 -> gnt=4'b0100 one cycle later; next cycle data_out=8'h55, owner=2, valid=1.
- req=4'b1111 held with data 11,22,33,44 and pointer 0 -> grants in order 0,1,2,3,0 on every other cycle; data_out follows 11,22,33,44,11.
- req[1] asserted, dropped during its GRANT cycle -> gnt pulses once, data_out/owner unchanged, next grant goes to requester 1 again if it re-requests.
- clr=1 and req[0]=1 both in IDLE -> data_out=0, valid=0, no gnt. Next cycle with clr=0 -> gnt=4'b0001.
- rst_n pulsed low mid-GRANT (req[3], 8'hAA) -> immediately gnt=0, data_out=0, valid=0; no write of 8'hAA.
- REG_ARB_LOCK_EN: lock[1]=1 with req[1], req[2] active -> requester 1 receives consecutive writes until lock[1]=0; then the next grant goes to requester 2.
